// File: rtl/morse_pkg.sv
// Shared Morse digit definitions: FSM states, the digit/pattern table and timing defaults.
// Imported by both the digit encoder and the decoder so they always agree on the code book.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    DECODE,
    ERR_WAIT
  } state_t;

  localparam int SYMS_PER_DIGIT = 5;
  localparam int NUM_DIGITS     = 10;

  // Pattern for digit i sits at index i; MSB is the first symbol sent, 1 = dash.
  localparam logic [NUM_DIGITS-1:0][SYMS_PER_DIGIT-1:0] DIGIT_CODE = {
    5'b11110,  // 9
    5'b11100,  // 8
    5'b11000,  // 7
    5'b10000,  // 6
    5'b00000,  // 5
    5'b00001,  // 4
    5'b00011,  // 3
    5'b00111,  // 2
    5'b01111,  // 1
    5'b11111   // 0
  };

  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/morse_key_sync.sv
// Two-flop synchronizer bringing the raw key line into the clk domain.
// Both stages reset to 0 so a held key cannot look like a mark straight out of reset.
module morse_key_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/morse_code_decoder.sv
// Single-digit Morse receiver: times marks and spaces on the synchronized key line,
// classifies dots/dashes into a 5-bit code and looks the code up in the digit table.
module morse_code_decoder
  import morse_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int GLITCH_LEN = CLK_HZ / 100,
  parameter int DASH_MIN   = 2 * CLK_HZ,
  parameter int CHAR_GAP   = 2 * CLK_HZ,
  parameter int MARK_MAX   = 5 * CLK_HZ,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       error,
  output logic       busy
);

  localparam int LEN_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(MARK_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CHAR_GAP - 1);

  logic key_s;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [SYMS_PER_DIGIT-1:0] code_reg, code_next;
  logic [2:0]                sym_cnt_reg, sym_cnt_next;
  logic [3:0]                digit_reg, digit_next;
  logic                      valid_reg, valid_next;
  logic                      error_reg, error_next;
  logic                      busy_reg, busy_next;

  logic [LEN_W-1:0]          mark_len;
  logic [2:0]                sym_inc;
  logic [NUM_DIGITS-1:0]     hit;
  logic                      match;
  logic [3:0]                match_digit;
  logic                      is_dash;

  morse_key_sync u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  // The cycle that detected the rising key was spent in IDLE/SPACE, so the
  // mark has lasted one cycle more than the MARK counter shows at release.
  assign mark_len = {1'b0, cnt_reg} + LEN_W'(1);
  assign sym_inc  = sym_cnt_reg + 3'd1;
  assign is_dash  = (mark_len >= LEN_W'(DASH_MIN));

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_match
    assign hit[gi] = (code_reg == DIGIT_CODE[gi]);
  end

  always_comb begin
    match       = 1'b0;
    match_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hit[i]) begin
        match       = 1'b1;
        match_digit = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      code_reg    <= '0;
      sym_cnt_reg <= '0;
      digit_reg   <= '0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      code_reg    <= code_next;
      sym_cnt_reg <= sym_cnt_next;
      digit_reg   <= digit_next;
      valid_reg   <= valid_next;
      error_reg   <= error_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    code_next    = code_reg;
    sym_cnt_next = sym_cnt_reg;
    digit_next   = digit_reg;
    valid_next   = 1'b0;
    error_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (key_s) state_next = MARK;
      end
      MARK: begin
        // Release is evaluated first so a release on the timeout cycle still counts.
        if (!key_s) begin
          if (mark_len < LEN_W'(GLITCH_LEN)) begin
            state_next = (sym_cnt_reg != 3'd0) ? SPACE : IDLE;
          end else begin
            code_next    = {code_reg[SYMS_PER_DIGIT-2:0], is_dash};
            sym_cnt_next = sym_inc;
            state_next   = (sym_inc == 3'(SYMS_PER_DIGIT)) ? DECODE : SPACE;
          end
        end else if (cnt_reg == MARK_LAST) begin
          state_next = ERR_WAIT;
          error_next = 1'b1;
        end
      end
      SPACE: begin
        if (key_s) begin
          state_next = MARK;
        end else if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      DECODE: begin
        if (match) begin
          digit_next = match_digit;
          valid_next = 1'b1;
        end else begin
          error_next = 1'b1;
        end
        state_next = key_s ? ERR_WAIT : IDLE;
      end
      ERR_WAIT: begin
        if (!key_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next == IDLE) begin
      code_next    = '0;
      sym_cnt_next = '0;
    end
  end

  always_comb begin
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (&cnt_reg) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign busy_next   = (state_next != IDLE);

  assign digit_out   = digit_reg;
  assign digit_valid = valid_reg;
  assign error       = error_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_morse_code_decoder.sv
// Scoreboard bench for morse_code_decoder at CLK_HZ=100: expected digits/errors are
// queued as each character is keyed and matched against the decoder's output pulses.
module tb_morse_code_decoder;

  logic       clk;
  logic       rst;
  logic       key_in;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       error;
  logic       busy;

  typedef struct {
    bit is_err;
    int digit;
  } ev_t;

  ev_t sb[$];
  ev_t ev_pop;
  int  n_checks = 0;
  int  n_errs   = 0;

  morse_code_decoder #(.CLK_HZ(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .error       (error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", tag, got, $time);
    end
  endtask

  task automatic push_digit(input int d);
    ev_t e;
    e.is_err = 1'b0;
    e.digit  = d;
    sb.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.digit  = 0;
    sb.push_back(e);
  endtask

  // Key high for hi sampled edges, then low for lo edges; returns #2 after an edge.
  task automatic mark(input int hi, input int lo);
    key_in = 1'b1;
    repeat (hi) @(posedge clk);
    #2;
    key_in = 1'b0;
    repeat (lo) @(posedge clk);
    #2;
  endtask

  // Encoder-style timing: dot 100, dash 300, 50 between symbols, tail after the 5th.
  task automatic send_digit(input int d, input int tail);
    int k;
    bit dash;
    push_digit(d);
    for (int i = 0; i < 5; i++) begin
      if (d >= 1 && d <= 5) begin
        dash = (i >= d);
      end else begin
        k    = (d == 0) ? 5 : d - 5;
        dash = (i < k);
      end
      mark(dash ? 300 : 100, (i == 4) ? tail : 50);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (digit_valid || error)) begin
      check("excl_valid_error", 32'(digit_valid & error), 0);
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, error, digit_valid}, 0);
      end else begin
        ev_pop = sb.pop_front();
        check("event_is_error", 32'(error), 32'(ev_pop.is_err));
        if (!ev_pop.is_err) check("digit_out", 32'(digit_out), 32'(ev_pop.digit));
      end
    end
  end

  initial begin
    int lat;
    int waited;
    rst    = 1'b1;
    key_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digit_out", 32'(digit_out), 0);
    check("rst_valid", 32'(digit_valid), 0);
    check("rst_error", 32'(error), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    // 1: --... = 7, pulse exactly 4 edges after the last fall
    push_digit(7);
    mark(300, 50);
    mark(300, 50);
    mark(100, 50);
    mark(100, 50);
    mark(100, 0);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (digit_valid && lat == 0) lat = k;
    end
    check("t1_latency", 32'(lat), 4);
    repeat (250) @(posedge clk);
    #2;
    check("t1_digit_hold", 32'(digit_out), 7);
    check("t1_busy_idle", 32'(busy), 0);

    // 2: 199 is a dot, 200 a dash -> .-... is not a digit
    push_err();
    mark(199, 50);
    mark(200, 50);
    mark(199, 50);
    mark(199, 50);
    mark(199, 250);
    check("t2_digit_unchanged", 32'(digit_out), 7);

    // 3: three dots then silence -> CHAR_GAP abort, then a normal 2
    push_err();
    mark(100, 50);
    mark(100, 50);
    mark(100, 260);
    check("t3_busy_after_gap", 32'(busy), 0);
    send_digit(2, 300);
    check("t3_digit_after", 32'(digit_out), 2);

    // 4: stuck key -> MARK_MAX abort, no decode on release, then a 4
    push_err();
    key_in = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("t4_busy_in_mark", 32'(busy), 1);
    repeat (300) @(posedge clk);
    #2;
    key_in = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check("t4_busy_after_release", 32'(busy), 0);
    send_digit(4, 300);
    check("t4_digit", 32'(digit_out), 4);

    // 5: reset after two symbols of a 9 drops everything
    mark(300, 50);
    mark(300, 20);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_digit_out", 32'(digit_out), 0);
    check("t5_rst_valid", 32'(digit_valid), 0);
    check("t5_rst_error", 32'(error), 0);
    check("t5_rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (250) @(posedge clk);
    #2;
    check("t5_busy_idle", 32'(busy), 0);
    send_digit(9, 300);
    check("t5_digit", 32'(digit_out), 9);

    // 6: encoder-style stream of every digit
    for (int d = 0; d < 10; d++) begin
      send_digit(d, 300);
    end
    check("t6_last_digit", 32'(digit_out), 9);

    waited = 0;
    while (sb.size() != 0 && waited < 1000) begin
      @(posedge clk);
      waited++;
    end
    check("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
